midi_tx_arbiter: RTL and testbench

MIDI_TX_ARBITER -- requirements
Module: midi_tx_arbiter

---
 rtl/midi_tx_arbiter_if.sv | 26 ++
 rtl/midi_tx_arbiter.sv | 163 ++++++++++++++++
 tb/tb_midi_tx_arbiter.sv | 316 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/midi_tx_arbiter_if.sv
// Bundle between the MIDI requesters, the arbiter and the UART-style transmitter.
// The requesters drive from the master side; the arbiter sits on the slave side.
interface midi_tx_arbiter_if;
  logic [3:0]  req;
  logic [31:0] req_status;
  logic [31:0] req_data1;
  logic [31:0] req_data2;
  logic [3:0]  ack;
  logic [7:0]  tx_status;
  logic [7:0]  tx_data1;
  logic [7:0]  tx_data2;
  logic [7:0]  tx_bits_cnt;
  logic        tx_cmd_set;
  logic        busy;
  logic        err;

  modport master (
    output req, req_status, req_data1, req_data2,
    input  ack, tx_status, tx_data1, tx_data2, tx_bits_cnt, tx_cmd_set, busy, err
  );

  modport slave (
    input  req, req_status, req_data1, req_data2,
    output ack, tx_status, tx_data1, tx_data2, tx_bits_cnt, tx_cmd_set, busy, err
  );
endinterface

// File: rtl/midi_tx_arbiter.sv
// Round-robin arbiter for four MIDI message sources feeding one transmitter.
// It holds the line busy for the message length plus a guard gap before the next grant.
module midi_tx_arbiter #(
  parameter int unsigned BIT_CYCLES = 3200,
  parameter int unsigned GUARD_BITS = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  midi_tx_arbiter_if.slave     bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [1:0]  r_ptr;
  logic [1:0]  w_ptr_nxt;
  logic [19:0] r_timer;
  logic [19:0] w_timer_nxt;
  logic [19:0] w_timer_load;
  logic [1:0]  r_nbytes;
  logic [7:0]  r_tx_status;
  logic [7:0]  r_tx_data1;
  logic [7:0]  r_tx_data2;
  logic [7:0]  r_tx_bits_cnt;
  logic        w_found;
  logic [1:0]  w_winner;
  logic [7:0]  w_win_status;
  logic [7:0]  w_win_data1;
  logic [7:0]  w_win_data2;
  logic [1:0]  w_win_bytes;
  logic [3:0]  w_ack;
  logic        w_err;
  logic        w_load;

  // Message length from the status byte; zero marks a non-status byte that gets dropped.
  function automatic logic [1:0] msg_bytes(input logic [7:0] status);
    logic [1:0] n;
    if (status[7] == 1'b0) begin
      n = 2'd0;
    end else if (status[7:4] == 4'hC || status[7:4] == 4'hD) begin
      n = 2'd2;
    end else if (status[7:4] != 4'hF) begin
      n = 2'd3;
    end else if (status == 8'hF1 || status == 8'hF3) begin
      n = 2'd2;
    end else if (status == 8'hF2) begin
      n = 2'd3;
    end else begin
      n = 2'd1;
    end
    return n;
  endfunction

  // Round-robin search: first active request at or after the pointer, wrapping mod 4.
  always_comb begin
    w_found  = 1'b0;
    w_winner = r_ptr;
    for (int k = 0; k < 4; k++) begin
      if (!w_found && bus.req[r_ptr + 2'(k)]) begin
        w_found  = 1'b1;
        w_winner = r_ptr + 2'(k);
      end else begin
        w_found  = w_found;
      end
    end
  end

  assign w_win_status = bus.req_status[{w_winner, 3'b000} +: 8];
  assign w_win_data1  = bus.req_data1[{w_winner, 3'b000} +: 8];
  assign w_win_data2  = bus.req_data2[{w_winner, 3'b000} +: 8];
  assign w_win_bytes  = msg_bytes(w_win_status);

  // Busy window covers the message bits plus the guard gap, minus one for the terminal zero.
  assign w_timer_load = 20'((32'(r_nbytes) + GUARD_BITS) * (32'd10 * BIT_CYCLES) - 32'd1);

  // State register and all registered datapath.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_ptr         <= 2'd0;
      r_timer       <= 20'd0;
      r_nbytes      <= 2'd0;
      r_tx_status   <= 8'd0;
      r_tx_data1    <= 8'd0;
      r_tx_data2    <= 8'd0;
      r_tx_bits_cnt <= 8'd0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      r_timer <= w_timer_nxt;
      if (w_load) begin
        r_nbytes      <= w_win_bytes;
        r_tx_status   <= w_win_status;
        r_tx_data1    <= (w_win_bytes >= 2'd2) ? w_win_data1 : 8'd0;
        r_tx_data2    <= (w_win_bytes == 2'd3) ? w_win_data2 : 8'd0;
        r_tx_bits_cnt <= 8'(w_win_bytes) * 8'd10;
      end else begin
        r_nbytes      <= r_nbytes;
        r_tx_status   <= r_tx_status;
        r_tx_data1    <= r_tx_data1;
        r_tx_data2    <= r_tx_data2;
        r_tx_bits_cnt <= r_tx_bits_cnt;
      end
    end
  end

  // Next-state, grant and timer logic.
  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_timer_nxt = r_timer;
    w_ack       = 4'b0000;
    w_err       = 1'b0;
    w_load      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_found) begin
          w_ack     = 4'b0001 << w_winner;
          w_ptr_nxt = w_winner + 2'd1;
          if (w_win_bytes == 2'd0) begin
            w_err       = 1'b1;
            w_state_nxt = ST_IDLE;
          end else begin
            w_load      = 1'b1;
            w_state_nxt = ST_ISSUE;
          end
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        w_timer_nxt = w_timer_load;
        w_state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        if (r_timer == 20'd0) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_timer_nxt = r_timer - 20'd1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Strobes are suppressed while reset is being sampled so an aborted slot emits nothing.
  assign bus.ack         = rst ? 4'b0000 : w_ack;
  assign bus.err         = !rst && w_err;
  assign bus.tx_cmd_set  = !rst && (r_state == ST_ISSUE);
  assign bus.busy        = (r_state != ST_IDLE);
  assign bus.tx_status   = r_tx_status;
  assign bus.tx_data1    = r_tx_data1;
  assign bus.tx_data2    = r_tx_data2;
  assign bus.tx_bits_cnt = r_tx_bits_cnt;

endmodule

// File: tb/tb_midi_tx_arbiter.sv
// Self-checking bench for midi_tx_arbiter: directed scenarios plus random traffic,
// compared every cycle against a busy-countdown model of the arbitration rules.
module tb_midi_tx_arbiter;
  localparam int unsigned BC = 5;
  localparam int unsigned GB = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  midi_tx_arbiter_if bus();

  midi_tx_arbiter #(.BIT_CYCLES(BC), .GUARD_BITS(GB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int failures = 0;

  // requester side
  bit         rq[4];
  bit         rearm[4];
  logic [7:0] rs[4];
  logic [7:0] r1[4];
  logic [7:0] r2[4];
  bit         rnd_mode = 1'b0;
  bit         rst_req = 1'b0;

  // reference model
  int         m_ptr = 0;
  int         m_busy = 0;
  bit         m_first = 1'b0;
  logic [7:0] m_st = 8'd0;
  logic [7:0] m_d1 = 8'd0;
  logic [7:0] m_d2 = 8'd0;
  logic [7:0] m_bits = 8'd0;

  // observations of the DUT, later compared against constants
  int         obs_q[$];
  int         busy_run = 0;
  int         last_busy_len = 0;
  int         busy_cycles = 0;
  int         err_cnt = 0;
  int         cmd_cnt = 0;
  logic [3:0] err_ack = 4'd0;
  logic [7:0] cap_st = 8'd0;
  logic [7:0] cap_d1 = 8'd0;
  logic [7:0] cap_d2 = 8'd0;
  logic [7:0] cap_bits = 8'd0;

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int msg_len(input logic [7:0] s);
    if (s < 8'h80) return 0;
    if (s >= 8'hC0 && s <= 8'hDF) return 2;
    if (s <= 8'hEF) return 3;
    case (s)
      8'hF1, 8'hF3: return 2;
      8'hF2:        return 3;
      default:      return 1;
    endcase
  endfunction

  task automatic new_msg(input int i);
    rq[i] = 1'b1;
    rs[i] = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 127)) : 8'($urandom_range(128, 255));
    r1[i] = 8'($urandom_range(1, 255));
    r2[i] = 8'($urandom_range(1, 255));
  endtask

  // One clock: drive inputs after the edge, check at the falling edge, advance the model.
  task automatic step();
    logic [3:0] reqv;
    logic [3:0] eack;
    bit         eerr;
    bit         ebusy;
    bit         ecmd;
    int         w;
    int         n;
    int         idx;
    @(posedge clk);
    #1;
    rst = rst_req;
    for (int i = 0; i < 4; i++) begin
      reqv[i] = rq[i];
      bus.req_status[8*i +: 8] = rs[i];
      bus.req_data1[8*i +: 8]  = r1[i];
      bus.req_data2[8*i +: 8]  = r2[i];
    end
    bus.req = reqv;
    @(negedge clk);
    ebusy = (m_busy > 0);
    ecmd  = !rst_req && (m_busy > 0) && m_first;
    eack  = 4'd0;
    eerr  = 1'b0;
    w     = -1;
    if (!rst_req && m_busy == 0) begin
      for (int k = 0; k < 4; k++) begin
        idx = (m_ptr + k) % 4;
        if (w < 0 && reqv[idx]) w = idx;
      end
    end
    if (w >= 0) begin
      eack[w] = 1'b1;
      eerr = (msg_len(rs[w]) == 0);
    end
    chk_eq("ack", 32'(bus.ack), 32'(eack));
    chk_eq("err", 32'(bus.err), 32'(eerr));
    chk_eq("busy", 32'(bus.busy), 32'(ebusy));
    chk_eq("tx_cmd_set", 32'(bus.tx_cmd_set), 32'(ecmd));
    chk_eq("tx_status", 32'(bus.tx_status), 32'(m_st));
    chk_eq("tx_data1", 32'(bus.tx_data1), 32'(m_d1));
    chk_eq("tx_data2", 32'(bus.tx_data2), 32'(m_d2));
    chk_eq("tx_bits_cnt", 32'(bus.tx_bits_cnt), 32'(m_bits));

    for (int k = 0; k < 4; k++) if (bus.ack[k]) obs_q.push_back(k);
    if (bus.err) begin
      err_cnt++;
      err_ack = bus.ack;
    end
    if (bus.tx_cmd_set) begin
      cmd_cnt++;
      cap_st = bus.tx_status;
      cap_d1 = bus.tx_data1;
      cap_d2 = bus.tx_data2;
      cap_bits = bus.tx_bits_cnt;
    end
    if (bus.busy) begin
      busy_run++;
      busy_cycles++;
    end else begin
      if (busy_run > 0) last_busy_len = busy_run;
      busy_run = 0;
    end

    if (rst_req) begin
      m_ptr = 0; m_busy = 0; m_first = 1'b0;
      m_st = 8'd0; m_d1 = 8'd0; m_d2 = 8'd0; m_bits = 8'd0;
    end else if (m_busy > 0) begin
      m_busy--;
      m_first = 1'b0;
    end else if (w >= 0) begin
      m_ptr = (w + 1) % 4;
      n = msg_len(rs[w]);
      if (n > 0) begin
        m_busy = 1 + (n + GB) * 10 * BC;
        m_first = 1'b1;
        m_st = rs[w];
        m_d1 = (n >= 2) ? r1[w] : 8'd0;
        m_d2 = (n == 3) ? r2[w] : 8'd0;
        m_bits = 8'(n * 10);
      end
      if (!rearm[w]) rq[w] = 1'b0;
    end

    if (rnd_mode) begin
      for (int i = 0; i < 4; i++) begin
        if (!rq[i] && $urandom_range(0, 19) == 0) new_msg(i);
        else if (rq[i] && $urandom_range(0, 299) == 0) rq[i] = 1'b0;
      end
      rst_req = ($urandom_range(0, 3999) == 0);
    end
  endtask

  task automatic run_until_idle(input int maxc);
    int n;
    n = 0;
    step();
    while ((bus.busy || m_busy > 0) && n < maxc) begin
      step();
      n++;
    end
    chk_eq("idle_timeout", 32'(n < maxc), 32'd1);
  endtask

  task automatic reset_dut();
    for (int i = 0; i < 4; i++) begin
      rq[i] = 1'b0;
      rearm[i] = 1'b0;
    end
    rst_req = 1'b1;
    step();
    rst_req = 1'b0;
    obs_q.delete();
    err_cnt = 0;
    cmd_cnt = 0;
    busy_cycles = 0;
  endtask

  initial begin
    int order[5];
    order = '{0, 1, 2, 3, 0};
    for (int i = 0; i < 4; i++) begin
      rs[i] = 8'd0; r1[i] = 8'd0; r2[i] = 8'd0;
    end
    rst = 1'b1;
    bus.req = 4'd0;
    bus.req_status = 32'd0;
    bus.req_data1 = 32'd0;
    bus.req_data2 = 32'd0;
    repeat (2) @(posedge clk);

    // reset state
    reset_dut();
    step();
    chk_eq("rst_busy", 32'(bus.busy), 32'd0);
    chk_eq("rst_bits", 32'(bus.tx_bits_cnt), 32'd0);
    chk_eq("rst_cmd", 32'(bus.tx_cmd_set), 32'd0);

    // single 3-byte note-on
    reset_dut();
    rq[0] = 1'b1; rs[0] = 8'h90; r1[0] = 8'h3C; r2[0] = 8'h7F;
    step();
    run_until_idle(2000);
    chk_eq("note_grant_cnt", 32'(obs_q.size()), 32'd1);
    chk_eq("note_grant_id", 32'(obs_q[0]), 32'd0);
    chk_eq("note_cmd_cnt", 32'(cmd_cnt), 32'd1);
    chk_eq("note_bits", 32'(cap_bits), 32'd30);
    chk_eq("note_status", 32'(cap_st), 32'h90);
    chk_eq("note_d1", 32'(cap_d1), 32'h3C);
    chk_eq("note_d2", 32'(cap_d2), 32'h7F);
    chk_eq("note_busy_len", 32'(last_busy_len), 32'(1 + (3 + GB) * 10 * BC));

    // all four requesting continuously
    reset_dut();
    for (int i = 0; i < 4; i++) begin
      rq[i] = 1'b1; rearm[i] = 1'b1;
      rs[i] = 8'h90 + 8'(i); r1[i] = 8'h10 + 8'(i); r2[i] = 8'h20 + 8'(i);
    end
    begin
      int n;
      n = 0;
      while (obs_q.size() < 5 && n < 3000) begin
        step();
        n++;
      end
      chk_eq("rr_timeout", 32'(n < 3000), 32'd1);
    end
    for (int i = 0; i < 5; i++) begin
      if (i < obs_q.size()) chk_eq("rr_order", 32'(obs_q[i]), 32'(order[i]));
      else chk_eq("rr_order_missing", 32'(obs_q.size()), 32'd5);
    end
    for (int i = 0; i < 4; i++) begin
      rearm[i] = 1'b0; rq[i] = 1'b0;
    end
    run_until_idle(2000);

    // 2-byte program change
    reset_dut();
    rq[2] = 1'b1; rs[2] = 8'hC5; r1[2] = 8'h10; r2[2] = 8'h55;
    step();
    run_until_idle(2000);
    chk_eq("pc_bits", 32'(cap_bits), 32'd20);
    chk_eq("pc_d1", 32'(cap_d1), 32'h10);
    chk_eq("pc_d2", 32'(cap_d2), 32'h00);
    chk_eq("pc_wait_len", 32'(last_busy_len - 1), 32'(40 * BC));

    // non-status byte is acked with err and dropped
    reset_dut();
    rq[1] = 1'b1; rs[1] = 8'h45; r1[1] = 8'h11; r2[1] = 8'h22;
    repeat (6) step();
    chk_eq("drop_err_cnt", 32'(err_cnt), 32'd1);
    chk_eq("drop_err_ack", 32'(err_ack), 32'b0010);
    chk_eq("drop_cmd_cnt", 32'(cmd_cnt), 32'd0);
    chk_eq("drop_busy", 32'(busy_cycles), 32'd0);

    // 1-byte system real-time message
    reset_dut();
    rq[3] = 1'b1; rs[3] = 8'hF8; r1[3] = 8'hAA; r2[3] = 8'hBB;
    step();
    run_until_idle(2000);
    chk_eq("rt_status", 32'(cap_st), 32'hF8);
    chk_eq("rt_bits", 32'(cap_bits), 32'd10);
    chk_eq("rt_d1", 32'(cap_d1), 32'h00);
    chk_eq("rt_d2", 32'(cap_d2), 32'h00);

    // reset in the middle of a wait
    reset_dut();
    rq[0] = 1'b1; rs[0] = 8'h90; r1[0] = 8'h01; r2[0] = 8'h02;
    repeat (22) step();
    rst_req = 1'b1;
    step();
    rst_req = 1'b0;
    step();
    chk_eq("midrst_busy", 32'(bus.busy), 32'd0);
    chk_eq("midrst_cmd", 32'(bus.tx_cmd_set), 32'd0);
    obs_q.delete();
    rq[1] = 1'b1; rs[1] = 8'hB0; r1[1] = 8'h07; r2[1] = 8'h40;
    rq[2] = 1'b1; rs[2] = 8'hE0; r1[2] = 8'h00; r2[2] = 8'h40;
    step();
    chk_eq("midrst_first", 32'(obs_q.size() > 0 ? obs_q[0] : -1), 32'd1);
    run_until_idle(2000);
    step();
    run_until_idle(2000);

    // randomized traffic, drops and occasional resets
    reset_dut();
    rnd_mode = 1'b1;
    repeat (20000) step();
    rnd_mode = 1'b0;
    rst_req = 1'b0;
    for (int i = 0; i < 4; i++) rq[i] = 1'b0;
    run_until_idle(2000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
